// File: rtl/program_run_monitor_if.sv
// Control, program-table, core-facing and status signals of program_run_monitor.
// slave = the monitor itself; master = whoever drives the program table and models or hosts the core.
interface program_run_monitor_if #(
  parameter int DATA_W    = 64,
  parameter int NUM_PROGS = 4
);
  localparam int IDX_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  logic                        start;
  logic [NUM_PROGS*DATA_W-1:0] prog_startpc;
  logic [NUM_PROGS*DATA_W-1:0] prog_endpc;
  logic [NUM_PROGS*DATA_W-1:0] prog_expect;
  logic [DATA_W-1:0]           currentpc;
  logic [DATA_W-1:0]           MemtoRegOut;
  logic                        cpu_resetl;
  logic [DATA_W-1:0]           cpu_startpc;
  logic [IDX_W-1:0]            prog_idx;
  logic [NUM_PROGS-1:0]        pass_vec;
  logic [7:0]                  pass_count;
  logic                        busy;
  logic                        done;
  logic                        all_passed;
  logic                        timeout;

  modport slave (
    input  start, prog_startpc, prog_endpc, prog_expect, currentpc, MemtoRegOut,
    output cpu_resetl, cpu_startpc, prog_idx, pass_vec, pass_count,
           busy, done, all_passed, timeout
  );

  modport master (
    output start, prog_startpc, prog_endpc, prog_expect, currentpc, MemtoRegOut,
    input  cpu_resetl, cpu_startpc, prog_idx, pass_vec, pass_count,
           busy, done, all_passed, timeout
  );
endinterface

// File: rtl/program_run_monitor.sv
// Sequences programs on the core (hold reset, run to end PC, check writeback), with per-program watchdog.
// Latency: cpu_resetl rises on the first RUN cycle; result updates one edge after end PC is seen. start ignored while busy.
module program_run_monitor #(
  parameter int          DATA_W     = 64,
  parameter int          NUM_PROGS  = 4,
  parameter int          WD_W       = 16,
  parameter int unsigned WD_LIMIT   = 'h00FF,
  parameter int          RST_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    resetl,
  program_run_monitor_if.slave    bus
);
  localparam int IDX_W  = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PROGS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WD_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_CHECK, S_DONE, S_TIMEOUT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     prog_idx;
  logic [NUM_PROGS-1:0] pass_vec;
  logic [7:0]           pass_count;
  logic [WD_W-1:0]      wd;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [DATA_W-1:0]    capture;
  logic                 cpu_resetl, busy, done, all_passed, timeout;

  logic [DATA_W-1:0]    cur_endpc, cur_expect;
  logic                 hit;
  logic [7:0]           count_next;

  assign cur_endpc  = bus.prog_endpc[prog_idx*DATA_W +: DATA_W];
  assign cur_expect = bus.prog_expect[prog_idx*DATA_W +: DATA_W];
  assign hit        = (capture == cur_expect);
  assign count_next = (hit && pass_count != 8'hFF) ? pass_count + 8'd1 : pass_count;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state      <= S_IDLE;
      prog_idx   <= '0;
      pass_vec   <= '0;
      pass_count <= '0;
      wd         <= '0;
      hold_cnt   <= '0;
      capture    <= '0;
      cpu_resetl <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      all_passed <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (bus.start) begin
            state      <= S_HOLD;
            prog_idx   <= '0;
            pass_vec   <= '0;
            pass_count <= '0;
            wd         <= '0;
            hold_cnt   <= '0;
            cpu_resetl <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            all_passed <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            hold_cnt   <= '0;
            cpu_resetl <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // End PC takes priority over a watchdog expiring in the same cycle.
          if (bus.currentpc >= cur_endpc) begin
            capture    <= bus.MemtoRegOut;
            state      <= S_CHECK;
            cpu_resetl <= 1'b0;
          end else if (wd == WD_LAST) begin
            wd         <= wd + 1'b1;
            state      <= S_TIMEOUT;
            cpu_resetl <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_CHECK: begin
          if (hit) begin
            pass_vec[prog_idx] <= 1'b1;
            pass_count         <= count_next;
          end
          if (prog_idx == LAST_IDX) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            all_passed <= (count_next == 8'(NUM_PROGS));
          end else begin
            prog_idx <= prog_idx + 1'b1;
            state    <= S_HOLD;
            hold_cnt <= '0;
            wd       <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_resetl  = cpu_resetl;
  assign bus.cpu_startpc = bus.prog_startpc[prog_idx*DATA_W +: DATA_W];
  assign bus.prog_idx    = prog_idx;
  assign bus.pass_vec    = pass_vec;
  assign bus.pass_count  = pass_count;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.all_passed  = all_passed;
  assign bus.timeout     = timeout;
endmodule

// File: tb/tb_program_run_monitor.sv
// Bench for program_run_monitor: a simple stepping-PC core model plus a per-program reference model.
module tb_program_run_monitor;
  localparam int DW = 64, NP = 4, WDL = 16, RST = 2;

  logic CLK = 1'b0;
  logic resetl = 1'b0;
  always #5 CLK = ~CLK;

  program_run_monitor_if #(.DATA_W(DW), .NUM_PROGS(NP)) bus();

  program_run_monitor #(.DATA_W(DW), .NUM_PROGS(NP), .WD_W(16), .WD_LIMIT(WDL), .RST_CYCLES(RST)) dut (
    .CLK(CLK), .resetl(resetl), .bus(bus)
  );

  int checks = 0, failures = 0;

  logic [DW-1:0] cfg_start[NP], cfg_end[NP], cfg_exp[NP], cfg_step[NP];

  // Core: loads startpc while held in reset, then advances by the slot's step; writeback = pc + 2.
  logic [DW-1:0] core_pc;
  always @(posedge CLK)
    if (!bus.cpu_resetl) core_pc <= bus.cpu_startpc;
    else                 core_pc <= core_pc + cfg_step[bus.prog_idx];
  assign bus.currentpc   = core_pc;
  assign bus.MemtoRegOut = core_pc + 64'd2;

  logic [NP-1:0] exp_vec;
  int            exp_cnt, exp_idx, exp_busy;
  bit            exp_to;
  int            exp_len[NP], exp_low[NP];
  logic [DW-1:0] exp_spc[NP];

  int            obs_len[NP], obs_low[NP], obs_busy;
  logic [DW-1:0] obs_spc[NP];
  bit            obs_ok;

  task automatic apply_cfg();
    for (int s = 0; s < NP; s++) begin
      bus.prog_startpc[s*DW +: DW] = cfg_start[s];
      bus.prog_endpc[s*DW +: DW]   = cfg_end[s];
      bus.prog_expect[s*DW +: DW]  = cfg_exp[s];
    end
  endtask

  task automatic set_slot(input int s, input logic [DW-1:0] st, en, stp, ex);
    cfg_start[s] = st; cfg_end[s] = en; cfg_step[s] = stp; cfg_exp[s] = ex;
  endtask

  // Reference: program s reaches its end PC after k steps (k < WDL) or times out after WDL run cycles.
  task automatic model_run();
    int k;
    bit stop;
    exp_vec = '0; exp_cnt = 0; exp_to = 0; exp_idx = 0; exp_busy = 0; stop = 0;
    for (int s = 0; s < NP; s++) begin exp_len[s] = 0; exp_low[s] = 0; exp_spc[s] = '0; end
    for (int s = 0; s < NP && !stop; s++) begin
      k = -1;
      for (int n = 0; n < WDL; n++)
        if (k < 0 && cfg_start[s] + 64'(n) * cfg_step[s] >= cfg_end[s]) k = n;
      exp_idx = s;
      exp_low[s] = (s == 0) ? RST : RST + 1;
      exp_spc[s] = cfg_start[s];
      if (k < 0) begin
        exp_to = 1; exp_len[s] = WDL; exp_busy += RST + WDL; stop = 1;
      end else begin
        exp_len[s] = k + 1;
        exp_busy += RST + k + 2;
        if (cfg_start[s] + 64'(k) * cfg_step[s] + 64'd2 == cfg_exp[s]) begin
          exp_vec[s] = 1'b1; exp_cnt++;
        end
      end
    end
  endtask

  // Pulses start and records per-slot observations until done (bounded).
  task automatic do_run(input bit pulse_mid);
    int lowcnt;
    bit prev;
    obs_busy = 0; obs_ok = 0; lowcnt = 0; prev = 0;
    for (int s = 0; s < NP; s++) begin obs_len[s] = 0; obs_low[s] = 0; obs_spc[s] = '0; end
    @(negedge CLK); bus.start = 1'b1;
    @(negedge CLK); bus.start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge CLK);
      if (bus.done) begin obs_ok = 1; break; end
      if (bus.busy) obs_busy++;
      if (bus.cpu_resetl) begin
        obs_len[bus.prog_idx]++;
        if (!prev) begin
          obs_low[bus.prog_idx] = lowcnt;
          obs_spc[bus.prog_idx] = bus.cpu_startpc;
        end
        lowcnt = 0;
      end else if (bus.busy) lowcnt++;
      prev = bus.cpu_resetl;
      if (pulse_mid) bus.start = (c >= 10 && c < 13);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    set_slot(0, 64'h0000_1234_5678_9AB0 ^ 64'($urandom), 64'hFF, 64'd4, 64'd0);
    apply_cfg();
    resetl = 1'b0;
    #1;
    checks++; if (bus.cpu_resetl !== 1'b0) begin failures++; $display("FAIL reset_cpu_resetl got=%b want=0", bus.cpu_resetl); end
    checks++; if ({bus.busy, bus.done, bus.all_passed, bus.timeout} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {bus.busy, bus.done, bus.all_passed, bus.timeout}); end
    checks++; if (bus.pass_vec !== 4'b0 || bus.pass_count !== 8'd0) begin failures++; $display("FAIL reset_results got=%b/%0d want=0/0", bus.pass_vec, bus.pass_count); end
    checks++; if (bus.prog_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d want=0", bus.prog_idx); end
    checks++; if (bus.cpu_startpc !== cfg_start[0]) begin failures++; $display("FAIL reset_startpc got=%h want=%h", bus.cpu_startpc, cfg_start[0]); end
    @(negedge CLK); resetl = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (bus.busy !== 1'b0 || bus.cpu_resetl !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL idle_hold got busy=%b rl=%b done=%b want 0/0/0", bus.busy, bus.cpu_resetl, bus.done); end
  endtask

  task automatic test_single_pass();
    for (int s = 0; s < NP; s++) set_slot(s, 64'd0, 64'h1C, 64'd4, 64'd30);
    apply_cfg(); model_run(); do_run(0);
    checks++; if (!obs_ok) begin failures++; $display("FAIL pass_done got=no-done want=done"); end
    checks++; if (bus.all_passed !== 1'b1 || bus.timeout !== 1'b0) begin failures++; $display("FAIL pass_flags got ap=%b to=%b want 1/0", bus.all_passed, bus.timeout); end
    checks++; if (bus.pass_vec !== exp_vec || bus.pass_count !== 8'(exp_cnt)) begin failures++; $display("FAIL pass_vec got=%b/%0d want=%b/%0d", bus.pass_vec, bus.pass_count, exp_vec, exp_cnt); end
    checks++; if (obs_len[0] !== exp_len[0] || obs_low[0] !== exp_low[0]) begin failures++; $display("FAIL pass_timing got run=%0d low=%0d want run=%0d low=%0d", obs_len[0], obs_low[0], exp_len[0], exp_low[0]); end
    checks++; if (obs_low[1] !== exp_low[1]) begin failures++; $display("FAIL pass_rehold got=%0d want=%0d", obs_low[1], exp_low[1]); end
    checks++; if (bus.cpu_resetl !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL pass_done_state got rl=%b busy=%b want 0/0", bus.cpu_resetl, bus.busy); end
  endtask

  task automatic test_mismatch();
    cfg_exp[0] = 64'd29;
    apply_cfg(); model_run(); do_run(0);
    checks++; if (!obs_ok || bus.done !== 1'b1) begin failures++; $display("FAIL mism_done got=%b want=1", bus.done); end
    checks++; if (bus.pass_vec !== exp_vec || bus.all_passed !== 1'b0 || bus.timeout !== 1'b0) begin failures++; $display("FAIL mism_result got vec=%b ap=%b to=%b want vec=%b ap=0 to=0", bus.pass_vec, bus.all_passed, bus.timeout, exp_vec); end
  endtask

  task automatic test_timeout();
    set_slot(0, 64'd0, 64'h1C, 64'd4, 64'd30);
    set_slot(1, 64'h8, 64'h54, 64'd0, 64'd0);
    apply_cfg(); model_run(); do_run(0);
    checks++; if (!obs_ok || bus.timeout !== 1'b1 || bus.done !== 1'b1) begin failures++; $display("FAIL to_flag got to=%b done=%b want 1/1", bus.timeout, bus.done); end
    checks++; if (bus.prog_idx !== 2'(exp_idx)) begin failures++; $display("FAIL to_idx got=%0d want=%0d", bus.prog_idx, exp_idx); end
    checks++; if (bus.pass_vec !== exp_vec || bus.pass_count !== 8'(exp_cnt)) begin failures++; $display("FAIL to_vec got=%b/%0d want=%b/%0d", bus.pass_vec, bus.pass_count, exp_vec, exp_cnt); end
    checks++; if (obs_len[1] !== WDL) begin failures++; $display("FAIL to_len got=%0d want=%0d", obs_len[1], WDL); end
    checks++; if (bus.cpu_resetl !== 1'b0 || bus.all_passed !== 1'b0) begin failures++; $display("FAIL to_outs got rl=%b ap=%b want 0/0", bus.cpu_resetl, bus.all_passed); end
  endtask

  task automatic test_endpc_vs_watchdog();
    set_slot(0, 64'd0, 64'd60, 64'd4, 64'd62);
    set_slot(1, 64'd0, 64'd64, 64'd4, 64'd66);
    apply_cfg(); model_run(); do_run(0);
    checks++; if (obs_len[0] !== exp_len[0] || bus.pass_vec[0] !== 1'b1) begin failures++; $display("FAIL race_check got run=%0d pass=%b want run=%0d pass=1", obs_len[0], bus.pass_vec[0], exp_len[0]); end
    checks++; if (bus.timeout !== 1'b1 || bus.prog_idx !== 2'd1 || obs_len[1] !== WDL) begin failures++; $display("FAIL race_next got to=%b idx=%0d run=%0d want 1/1/%0d", bus.timeout, bus.prog_idx, obs_len[1], WDL); end
  endtask

  task automatic test_back_to_back();
    set_slot(0, 64'h40, 64'h60, 64'd4, 64'h62);
    set_slot(1, 64'h10, 64'h13, 64'd1, 64'h15);
    set_slot(2, 64'h00, 64'h20, 64'd8, 64'h21);
    set_slot(3, 64'h90, 64'h10, 64'd4, 64'h92);
    apply_cfg(); model_run();
    for (int r = 0; r < 2; r++) begin
      do_run(0);
      checks++; if (!obs_ok || bus.pass_vec !== 4'b1011 || bus.pass_count !== 8'd3) begin failures++; $display("FAIL b2b_vec run%0d got=%b/%0d want=1011/3", r, bus.pass_vec, bus.pass_count); end
      checks++; if (bus.all_passed !== 1'b0 || obs_busy !== exp_busy) begin failures++; $display("FAIL b2b_busy run%0d got ap=%b busy=%0d want 0/%0d", r, bus.all_passed, obs_busy, exp_busy); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] st, en;
    for (int it = 0; it < 10; it++) begin
      for (int s = 0; s < NP; s++) begin
        st = 64'($urandom_range(0, 40));
        en = 64'($urandom_range(0, 60));
        set_slot(s, st, en, ($urandom_range(0, 9) == 0) ? 64'd0 : 64'($urandom_range(1, 4)),
                 $urandom_range(0, 1) ? en + 64'd2 : st + 64'd2);
      end
      apply_cfg(); model_run(); do_run(0);
      checks++; if (!obs_ok || bus.timeout !== exp_to || bus.prog_idx !== 2'(exp_idx)) begin failures++; $display("FAIL rand_end it%0d got ok=%b to=%b idx=%0d want to=%b idx=%0d", it, obs_ok, bus.timeout, bus.prog_idx, exp_to, exp_idx); end
      checks++; if (bus.pass_vec !== exp_vec || bus.pass_count !== 8'(exp_cnt) || bus.all_passed !== (!exp_to && exp_cnt == NP)) begin failures++; $display("FAIL rand_res it%0d got=%b/%0d/%b want=%b/%0d", it, bus.pass_vec, bus.pass_count, bus.all_passed, exp_vec, exp_cnt); end
      checks++; if (obs_busy !== exp_busy) begin failures++; $display("FAIL rand_busy it%0d got=%0d want=%0d", it, obs_busy, exp_busy); end
      for (int s = 0; s < NP; s++) begin
        checks++; if (obs_len[s] !== exp_len[s] || obs_low[s] !== exp_low[s] || obs_spc[s] !== exp_spc[s]) begin failures++; $display("FAIL rand_slot it%0d s%0d got run=%0d low=%0d pc=%h want run=%0d low=%0d pc=%h", it, s, obs_len[s], obs_low[s], obs_spc[s], exp_len[s], exp_low[s], exp_spc[s]); end
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    for (int s = 0; s < NP; s++) set_slot(s, 64'(s * 256 + 256), 64'(s * 256 + 296), 64'd4, 64'(s * 256 + 298));
    apply_cfg(); model_run();
    @(negedge CLK); bus.start = 1'b1;
    @(negedge CLK); bus.start = 1'b0;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge CLK);
      if (bus.prog_idx == 2'd2 && bus.cpu_resetl) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL arst_reach got=no-slot2-run want=slot2-run"); end
    #2 resetl = 1'b0;
    #1;
    checks++; if ({bus.cpu_resetl, bus.busy, bus.done, bus.all_passed, bus.timeout} !== 5'b0) begin failures++; $display("FAIL arst_flags got=%b want=00000", {bus.cpu_resetl, bus.busy, bus.done, bus.all_passed, bus.timeout}); end
    checks++; if (bus.pass_vec !== 4'b0 || bus.pass_count !== 8'd0 || bus.prog_idx !== 2'd0) begin failures++; $display("FAIL arst_state got=%b/%0d/%0d want=0/0/0", bus.pass_vec, bus.pass_count, bus.prog_idx); end
    checks++; if (bus.cpu_startpc !== cfg_start[0]) begin failures++; $display("FAIL arst_startpc got=%h want=%h", bus.cpu_startpc, cfg_start[0]); end
    bus.start = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_start_in_reset got busy=%b want 0", bus.busy); end
    bus.start = 1'b0; resetl = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL arst_idle got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    do_run(1);
    checks++; if (!obs_ok || obs_busy !== exp_busy) begin failures++; $display("FAIL busy_start_ignored got busy=%0d want=%0d", obs_busy, exp_busy); end
    checks++; if (bus.pass_vec !== exp_vec || bus.all_passed !== 1'b1) begin failures++; $display("FAIL busy_start_result got=%b/%b want=%b/1", bus.pass_vec, bus.all_passed, exp_vec); end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int s = 0; s < NP; s++) set_slot(s, 64'd0, 64'd0, 64'd4, 64'd0);
    apply_cfg();
    repeat (2) @(negedge CLK);
    test_reset();
    test_single_pass();
    test_mismatch();
    test_timeout();
    test_endpc_vs_watchdog();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=stuck want=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
